// File: rtl/priority_encoder_pkg.sv
// Shared constants and a reference index function for the 8-to-3 priority encoder.
package priority_encoder_pkg;

    localparam int PE_DEFAULT_WIDTH = 8;
    localparam int PE_MAX_WIDTH     = 64;

    // Highest set bit of vec, 0 when vec is all zero; vectors up to PE_MAX_WIDTH bits.
    function automatic int pe_index(input logic [PE_MAX_WIDTH-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < PE_MAX_WIDTH; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_encoder_comb.sv
// Combinational priority encode: index of the highest set request bit, plus any-bit flag.
// Zero latency; no flow control.
module priority_encoder_comb
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH = PE_DEFAULT_WIDTH,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] idx,
    output logic             any
);

    // Ascending scan, so the last (highest) hit overwrites earlier ones.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                idx = i[OUT_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: out/valid carry the encode of in sampled one edge earlier.
// Latency 1 cycle, one result per cycle, no backpressure; synchronous active-low reset.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH = PE_DEFAULT_WIDTH,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("priority_encoder: WIDTH must be at least 2");
        end
    endgenerate

    logic [OUT_W-1:0] out_d;
    logic             valid_d;
    logic [OUT_W-1:0] out_q;
    logic             valid_q;

    priority_encoder_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .in  (in),
        .idx (out_d),
        .any (valid_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder at WIDTH=8 and WIDTH=16: directed literal vectors plus a per-cycle model check.
module tb_priority_encoder;
    import priority_encoder_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  in8;
    logic [15:0] in16;
    logic [2:0]  out8;
    logic        valid8;
    logic [3:0]  out16;
    logic        valid16;

    int n_pass  = 0;
    int n_total = 0;
    bit armed   = 1'b0;

    priority_encoder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .in    (in8),
        .out   (out8),
        .valid (valid8)
    );

    priority_encoder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .in    (in16),
        .out   (out16),
        .valid (valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit as floor(log2(v)), computed arithmetically.
    function automatic int hi_idx(input logic [63:0] v);
        logic [64:0] w;
        if (v == 64'd0) return 0;
        w = {1'b0, v} + 65'd1;
        return $clog2(w) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model check every cycle once reset has been seen.
    logic        s_rst;
    logic [7:0]  s_in8;
    logic [15:0] s_in16;
    int          e_out8, e_vld8, e_out16, e_vld16;
    always @(posedge clk) begin
        s_rst  = rst;
        s_in8  = in8;
        s_in16 = in16;
        if (!s_rst) armed = 1'b1;
        e_out8  = s_rst ? hi_idx({56'd0, s_in8}) : 0;
        e_vld8  = (s_rst && s_in8 != 8'd0) ? 1 : 0;
        e_out16 = s_rst ? hi_idx({48'd0, s_in16}) : 0;
        e_vld16 = (s_rst && s_in16 != 16'd0) ? 1 : 0;
        #1;
        if (armed) begin
            chk("model_out8",    int'(out8),    e_out8);
            chk("model_valid8",  int'(valid8),  e_vld8);
            chk("model_out16",   int'(out16),   e_out16);
            chk("model_valid16", int'(valid16), e_vld16);
        end
    end

    task automatic step(input logic r, input logic [7:0] v8, input logic [15:0] v16);
        @(negedge clk);
        rst  = r;
        in8  = v8;
        in16 = v16;
        @(posedge clk);
        #2;
    endtask

    // Apply one 8-bit vector and check the registered result against literals.
    task automatic dir(input string name, input logic r, input logic [7:0] v, input int eo, input int ev);
        step(r, v, {8'h00, v});
        chk({name, "_out"},   int'(out8),   eo);
        chk({name, "_valid"}, int'(valid8), ev);
    endtask

    initial begin
        logic [7:0]  r8;
        logic [15:0] r16;
        rst  = 1'b0;
        in8  = 8'b0000_1000;
        in16 = 16'h0008;

        dir("reset_hold0", 1'b0, 8'b0000_1000, 0, 0);
        dir("reset_hold1", 1'b0, 8'b0000_1000, 0, 0);
        dir("release",     1'b1, 8'b0000_1000, 3, 1);

        dir("hot0", 1'b1, 8'b0000_0001, 0, 1);
        dir("hot1", 1'b1, 8'b0000_0010, 1, 1);
        dir("hot2", 1'b1, 8'b0000_0100, 2, 1);
        dir("hot4", 1'b1, 8'b0001_0000, 4, 1);
        dir("hot6", 1'b1, 8'b0100_0000, 6, 1);
        dir("hot7", 1'b1, 8'b1000_0000, 7, 1);

        dir("multi_50", 1'b1, 8'b0101_0000, 6, 1);
        dir("multi_0c", 1'b1, 8'b0000_1100, 3, 1);
        dir("multi_29", 1'b1, 8'b0010_1001, 5, 1);
        dir("multi_ff", 1'b1, 8'b1111_1111, 7, 1);

        dir("zero",     1'b1, 8'h00, 0, 0);
        dir("bit0",     1'b1, 8'h01, 0, 1);

        dir("alt_a0", 1'b1, 8'b1000_0000, 7, 1);
        dir("alt_b0", 1'b1, 8'b0000_0010, 1, 1);
        dir("alt_a1", 1'b1, 8'b1000_0000, 7, 1);
        dir("alt_b1", 1'b1, 8'b0000_0010, 1, 1);
        dir("mid_rst",    1'b0, 8'b1000_0000, 0, 0);
        dir("resume_b",   1'b1, 8'b0000_0010, 1, 1);
        dir("resume_a",   1'b1, 8'b1000_0000, 7, 1);

        step(1'b1, 8'h00, 16'h8001);
        chk("w16_8001_out",   int'(out16),   15);
        chk("w16_8001_valid", int'(valid16), 1);
        step(1'b1, 8'h00, 16'h0100);
        chk("w16_0100_out",   int'(out16),   8);
        step(1'b1, 8'h00, 16'h0000);
        chk("w16_zero_valid", int'(valid16), 0);

        for (int i = 0; i < 1000; i++) begin
            r8  = ($urandom_range(0, 7) == 0) ? 8'h00  : 8'($urandom);
            r16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            step(1'b1, r8, r16);
            chk("rand_out8",  int'(out8),  pe_index({56'd0, r8}));
            chk("rand_out16", int'(out16), pe_index({48'd0, r16}));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
